condicionador_pulso: RTL and testbench

//   Button conditioner upstream of semaforo_1; drives its pulso input.

---
 rtl/condicionador_pkg.sv | 5 +
 rtl/condicionador_pulso_sincronizador.sv | 24 ++
 rtl/condicionador_pulso.sv | 129 ++++++++++++
 tb/tb_condicionador_pulso.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/condicionador_pkg.sv
// Shared types for the push-button conditioner feeding semaforo_1.
package condicionador_pkg;
    typedef enum logic [1:0] {OCIOSO, FILTRA_SUBIDA, PRESSIONADO, FILTRA_DESCIDA} estado_t;
    localparam int CONTAGEM_W = 8;
endpackage

// File: rtl/condicionador_pulso_sincronizador.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module sincronizador #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    generate
        if (STAGES < 2) begin : g_chk_stages
            $error("sincronizador: STAGES must be >= 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/condicionador_pulso.sv
// Button conditioner: sync, debounce, one pulse per accepted press, pulse counter.
// Optional `AUTO_REPEAT_EN adds hold-to-repeat pulses while PRESSIONADO.
module condicionador_pulso
    import condicionador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  botao_in,
    output logic                  pulso,
    output logic                  nivel,
    output logic [CONTAGEM_W-1:0] contagem_pulsos
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a single-cycle filter the FILTRA_* states are skipped entirely.
    localparam bit FILTRO_UNITARIO = (DEBOUNCE_CYCLES == 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
            $error("condicionador_pulso: DEBOUNCE_CYCLES must be >= 1");
        end
        if (REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_chk_repeat
            $error("condicionador_pulso: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
        end
    endgenerate

    logic             botao_s;
    estado_t          estado;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             repete;

    sincronizador #(.STAGES(2)) u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (botao_in),
        .q     (botao_s)
    );

    // cnt counts stable samples beyond the first; accept when D samples seen.
    assign cnt_nxt = cnt + 1'b1;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    logic [REP_W-1:0] rep;
    logic [REP_W-1:0] rep_nxt;

    assign rep_nxt = rep + 1'b1;
    assign repete  = (estado == PRESSIONADO) && botao_s && !pulso &&
                     (rep_nxt == REP_W'(REPEAT_DELAY));

    // Reloading to DELAY-PERIOD makes each later repeat land PERIOD cycles apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep <= '0;
        end else begin
            case (estado)
                PRESSIONADO:    if (botao_s) rep <= repete ? REP_W'(REPEAT_DELAY - REPEAT_PERIOD) : rep_nxt;
                FILTRA_DESCIDA: rep <= rep;
                default:        rep <= '0;
            endcase
        end
    end
`else
    assign repete = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            pulso  <= 1'b0;
            nivel  <= 1'b0;
        end else begin
            pulso <= repete;
            case (estado)
                OCIOSO: begin
                    nivel <= botao_s && FILTRO_UNITARIO;
                    if (botao_s) begin
                        cnt <= '0;
                        if (FILTRO_UNITARIO) begin
                            estado <= PRESSIONADO;
                            pulso  <= 1'b1;
                        end else begin
                            estado <= FILTRA_SUBIDA;
                        end
                    end
                end
                FILTRA_SUBIDA: begin
                    nivel <= botao_s && (cnt_nxt == CNT_FIM);
                    if (!botao_s) begin
                        estado <= OCIOSO;
                    end else if (cnt_nxt == CNT_FIM) begin
                        estado <= PRESSIONADO;
                        pulso  <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                PRESSIONADO: begin
                    nivel <= botao_s || !FILTRO_UNITARIO;
                    if (!botao_s) begin
                        cnt    <= '0;
                        estado <= FILTRO_UNITARIO ? OCIOSO : FILTRA_DESCIDA;
                    end
                end
                FILTRA_DESCIDA: begin
                    nivel <= botao_s || (cnt_nxt != CNT_FIM);
                    if (botao_s)                 estado <= PRESSIONADO;
                    else if (cnt_nxt == CNT_FIM) estado <= OCIOSO;
                    else                         cnt    <= cnt_nxt;
                end
                default: begin
                    estado <= OCIOSO;
                    nivel  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     contagem_pulsos <= '0;
        else if (pulso) contagem_pulsos <= contagem_pulsos + 1'b1;
    end
endmodule

// File: tb/tb_condicionador_pulso.sv
// Directed bench for condicionador_pulso: segment table plus multi-cycle sequences.
module tb_condicionador_pulso;
    import condicionador_pkg::*;

`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  botao_in;
    logic                  pulso;
    logic                  nivel;
    logic [CONTAGEM_W-1:0] contagem_pulsos;

    condicionador_pulso dut (
        .clk             (clk),
        .reset           (reset),
        .botao_in        (botao_in),
        .pulso           (pulso),
        .nivel           (nivel),
        .contagem_pulsos (contagem_pulsos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic botao;
        int   ciclos;
        int   exp_pulsos;
        logic exp_nivel;
        int   exp_cont;
    } vetor_t;

    vetor_t tab [0:15];
    int     n_vec;
    int     n_err;
    int     n_pulsos;
    logic   prev_p;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
        end
    endtask

    // Drive one input value for one clock; outputs sampled on the falling edge.
    task automatic tick(input logic b);
        botao_in = b;
        @(negedge clk);
        if (pulso === 1'b1) begin
            chk("pulso_isolado", 32'(prev_p), 0);
            n_pulsos++;
        end
        prev_p = pulso;
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_pulsos = 0; prev_p = 1'b0;

        // {botao, ciclos, pulsos no segmento, nivel no fim, contagem no fim}
        tab[0]  = '{1'b1, 3,  0, 1'b0, 1};  // 3-cycle glitch rejected
        tab[1]  = '{1'b0, 10, 0, 1'b0, 1};
        tab[2]  = '{1'b1, 4,  0, 1'b0, 1};  // exactly DEBOUNCE_CYCLES high
        tab[3]  = '{1'b0, 12, 1, 1'b0, 2};  // ...accepted once it reaches the FSM
        tab[4]  = '{1'b1, 1,  0, 1'b0, 2};  // bouncy press
        tab[5]  = '{1'b0, 1,  0, 1'b0, 2};
        tab[6]  = '{1'b1, 1,  0, 1'b0, 2};
        tab[7]  = '{1'b0, 1,  0, 1'b0, 2};
        tab[8]  = '{1'b1, 10, 1, 1'b1, 3};
        tab[9]  = '{1'b0, 1,  0, 1'b1, 3};  // bouncy release
        tab[10] = '{1'b1, 1,  0, 1'b1, 3};
        tab[11] = '{1'b0, 1,  0, 1'b1, 3};
        tab[12] = '{1'b1, 1,  0, 1'b1, 3};
        tab[13] = '{1'b0, 5,  0, 1'b1, 3};
        tab[14] = '{1'b0, 1,  0, 1'b0, 3};  // nivel drops here
        tab[15] = '{1'b0, 6,  0, 1'b0, 3};

        // Reset held with button pressed, then clean-latency check.
        reset = 1'b0; botao_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pulso", 32'(pulso), 0);
        chk("reset_nivel", 32'(nivel), 0);
        chk("reset_contagem", 32'(contagem_pulsos), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            chk("latencia_pulso", 32'(pulso), (i == 6) ? 1 : 0);
        end
        tick(1'b1);
        chk("latencia_contagem", 32'(contagem_pulsos), 1);
        chk("latencia_nivel", 32'(nivel), 1);
        repeat (12) tick(1'b0);

        for (int v = 0; v < 16; v++) begin
            n_pulsos = 0;
            repeat (tab[v].ciclos) tick(tab[v].botao);
            chk($sformatf("vet%0d_pulsos", v), 32'(n_pulsos), 32'(tab[v].exp_pulsos));
            chk($sformatf("vet%0d_nivel", v), 32'(nivel), 32'(tab[v].exp_nivel));
            chk($sformatf("vet%0d_contagem", v), 32'(contagem_pulsos), 32'(tab[v].exp_cont));
        end

        // Reset in the middle of a held press: debounce re-runs after release.
        repeat (10) tick(1'b1);
        #2 reset = 1'b0;
        #1;
        chk("reset_meio_pulso", 32'(pulso), 0);
        chk("reset_meio_nivel", 32'(nivel), 0);
        chk("reset_meio_contagem", 32'(contagem_pulsos), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        prev_p = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            chk("reset_meio_latencia", 32'(pulso), (i == 6) ? 1 : 0);
        end
        tick(1'b1);
        chk("reset_meio_contagem_pos", 32'(contagem_pulsos), 1);
        repeat (12) tick(1'b0);

        // Counter wrap over 256 clean presses.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("wrap_inicio", 32'(contagem_pulsos), 0);
        n_pulsos = 0;
        for (int p = 0; p < 256; p++) begin
            repeat (5) tick(1'b1);
            repeat (8) tick(1'b0);
        end
        chk("wrap_pulsos", 32'(n_pulsos), 256);
        chk("wrap_contagem", 32'(contagem_pulsos), 0);
        repeat (5) tick(1'b1);
        repeat (8) tick(1'b0);
        chk("wrap_257", 32'(contagem_pulsos), 1);

        // Long hold: repeat pulses only when auto-repeat is built in.
        n_pulsos = 0;
        repeat (5) tick(1'b1);
        tick(1'b1);
        chk("rep_aceite", 32'(pulso), 1);
        for (int off = 1; off <= 44; off++) begin
            tick(1'b1);
            chk($sformatf("rep_off%0d", off), 32'(pulso),
                (AR && (off == 16 || off == 24 || off == 32 || off == 40)) ? 1 : 0);
        end
        repeat (20) tick(1'b0);
        chk("rep_total", 32'(n_pulsos), AR ? 5 : 1);
        chk("rep_contagem", 32'(contagem_pulsos), AR ? 6 : 2);
        chk("rep_nivel_fim", 32'(nivel), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
